serial_deserializer: RTL and testbench
======================================

# serial_deserializer

Serial-in, parallel-out receiver that rebuilds WIDTH-bit words from a framed, bit-qualified serial stream and presents each word on a valid/ready output port. It sits at the far end of the serial shift-register chain: the chain's serial output drives `in`, and this block returns the data to parallel form for downstream logic. One output holding register decouples word completion from consumer back-pressure.

## Interface
- `WIDTH`, default 8: data bits per word; legal range ≥1.
- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in` input 1: serial data bit.
- `in_valid` input 1: qualifies `in` this cycle; the bit is ignored when low.
- `frame` input 1: marks the first bit of a word; sampled only when `in_valid`=1.
- `out` output WIDTH: completed word, first-received bit in MSB.
- `out_valid` output 1: `out` holds an unconsumed word.
- `out_ready` input 1: consumer accepts the word when `out_valid`&&`out_ready`.
- `overrun` output 1: one-cycle pulse; completed word dropped because the holding register was full.
- `frame_err` output 1: one-cycle pulse; `frame` arrived before the current word completed.
- `parity_err` output 1: parity status of the word in `out`; meaningful only while `out_valid`=1.

## Operation
- The state machine has two states: IDLE and SHIFT. It also has a bit counter of width clog2(WIDTH+1) and a WIDTH-bit shift register `sr`.
- IDLE:
  - Bits with `in_valid`=1 and `frame`=0 are discarded.
  - `in_valid`&&`frame`: `sr` <= {sr[WIDTH-2:0],in}, count <= 1, and the state goes to SHIFT.
  - When WIDTH=1, the word completes immediately and the state stays IDLE.
- SHIFT:
  - Each `in_valid` bit shifts into `sr` LSB-side and increments count.
  - Cycles with `in_valid`=0 hold all state, so gaps of any length are legal.
- Completion: the bit that brings count to WIDTH completes the word, and the state returns to IDLE.
  - If `out_valid`=0, or `out_ready`=1 in the same cycle, the completed word loads `out` and `out_valid`=1.
  - Otherwise the word is dropped, `overrun` pulses, and `out` keeps the old word.
- Early frame: `in_valid`&&`frame` while in SHIFT with count>0 and the word incomplete. `frame_err` pulses, the partial word is discarded, and this bit restarts the word as bit 0 (count <= 1).
- Output handshake:
  - `out_valid`&&`out_ready` with no completion in that cycle: `out_valid` <= 0, and `out` keeps its value.
  - `out` and `out_valid` never change while `out_valid`=1 and `out_ready`=0, except when a completion coincides with acceptance.

## Timing
- Reset values: state IDLE, count 0, `sr` 0, `out` 0, `out_valid` 0, `overrun` 0, `frame_err` 0, `parity_err` 0. Reset asserted mid-word discards the partial word.
- Latency: `out`/`out_valid` update at the same rising edge that samples the last bit. They are visible the next cycle, with 0 extra cycles.
- Throughput: one word per WIDTH valid bits, back-to-back, with no idle bit needed between frames.
- `overrun` and `frame_err` are registered and high for exactly one cycle per event.
- If completion and acceptance occur in the same cycle, the new word is loaded, `out_valid` stays 1, and there is no overrun.

## Configuration
- `SERIAL_DESERIALIZER_PARITY_EN` defined:
  - Each frame carries WIDTH data bits followed by one even-parity bit, so the XOR of data and parity is 0.
  - Completion occurs on the parity bit, and the parity bit is not stored in `out`.
  - `parity_err` loads 1 with the word on a parity mismatch and 0 otherwise.
  - `frame` on the parity-bit position counts as an early frame.
- `SERIAL_DESERIALIZER_PARITY_EN` undefined: frames are exactly WIDTH bits, and `parity_err` is constant 0.

## Test plan
- Reset, then WIDTH=8, serial 1,0,1,0,0,1,0,1 with `frame` on the first bit and `out_ready`=1: `out`=0xA5, `out_valid` high for 1 cycle, and `overrun`=`frame_err`=0.
- Same word with `in_valid` low for 3 cycles between bits 3 and 4: `out`=0xA5, and completion occurs 3 cycles later than in the gap-free case.
- Hold `out_ready`=0 and send 0x3C then 0xC3 back-to-back: `out` stays 0x3C, `overrun` pulses once on the 0xC3 last bit, and raising `out_ready` clears `out_valid`.
- Send 4 bits of a word, then `frame` with 0xFF: `frame_err` pulses on the restart bit, and `out`=0xFF after 8 more bits.
- Assert `reset` low after 5 bits of 0x5A, then release and send 0x0F: no word from the aborted frame, and `out`=0x0F.
- Macro defined: 0x07 with parity bit 1 gives `parity_err`=0; 0x07 with parity bit 0 gives `out`=0x07 and `parity_err`=1.

Source files
------------

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - framed serial-in, parallel-out receiver with one-word holding register
// Optional trailing even-parity bit per frame: SERIAL_DESERIALIZER_PARITY_EN
module serial_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   input  logic             in_valid,
   input  logic             frame,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   output logic             frame_err,
   output logic             parity_err
);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   localparam int FRAME_BITS = WIDTH + PAR;
   localparam int CW         = $clog2(FRAME_BITS + 1);
   // The final bit of a frame is taken straight from `in`, so only the earlier bits need storage.
   localparam int SR_W       = (FRAME_BITS > 1) ? FRAME_BITS - 1 : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [CW-1:0]     count;
   logic [SR_W-1:0]   sr;
   logic [SR_W:0]     cat;
   logic              word_done;
   logic [WIDTH-1:0]  done_word;

   assign cat       = {sr, in};
   assign done_word = cat[FRAME_BITS-1:PAR];

   always_comb begin
      word_done = 1'b0;
      if (in_valid) begin
         if (frame)
            word_done = (FRAME_BITS == 1);
         else if (state == SHIFT)
            word_done = (count == CW'(FRAME_BITS - 1));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         sr        <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;

         // A framed bit always starts a new word; in SHIFT it also abandons the partial one.
         if (in_valid) begin
            if (frame) begin
               frame_err <= (state == SHIFT);
               sr        <= cat[SR_W-1:0];
               count     <= word_done ? '0 : CW'(1);
               state     <= word_done ? IDLE : SHIFT;
            end else if (state == SHIFT) begin
               sr <= cat[SR_W-1:0];
               if (word_done) begin
                  count <= '0;
                  state <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
         end

         if (word_done) begin
            if (!out_valid || out_ready) begin
               out       <= done_word;
               out_valid <= 1'b1;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
               parity_err <= ^cat;
`endif
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifndef SERIAL_DESERIALIZER_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - directed self-checking bench for serial_deserializer
// Parity cases are built when SERIAL_DESERIALIZER_PARITY_EN is defined.
module tb_serial_deserializer;

   localparam int W = 8;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic         clk;
   logic         reset;
   logic         in;
   logic         in_valid;
   logic         frame;
   logic [W-1:0] out;
   logic         out_valid;
   logic         out_ready;
   logic         overrun;
   logic         frame_err;
   logic         parity_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t0;

   serial_deserializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in         (in),
      .in_valid   (in_valid),
      .frame      (frame),
      .out        (out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overrun    (overrun),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b, input logic f);
      in       = b;
      frame    = f;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      frame    = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] w, input int i);
      if (i < W)
         return w[W-1-i];
      return ^w;
   endfunction

   // Sends frame positions lo..hi of word w (position 0 = MSB, carries frame).
   task automatic send_range(input logic [7:0] w, input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         drive_bit(frame_bit(w, i), i == 0);
   endtask

   initial begin
      reset     = 1'b0;
      in        = 1'b0;
      in_valid  = 1'b0;
      frame     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", out, 8'h00);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_parity_err", parity_err, 1'b0);
      reset = 1'b1;
      idle(1);

      // Basic word, gap-free
      out_ready = 1'b1;
      t0 = cyc;
      send_range(8'hA5, 0, NB - 2);
      check("t1_pre_valid", out_valid, 1'b0);
      send_range(8'hA5, NB - 1, NB - 1);
      check("t1_out", out, 8'hA5);
      check("t1_valid", out_valid, 1'b1);
      check("t1_overrun", overrun, 1'b0);
      check("t1_frame_err", frame_err, 1'b0);
      check("t1_parity_err", parity_err, 1'b0);
      check("t1_latency", cyc - t0, NB);
      idle(1);
      check("t1_valid_one_cycle", out_valid, 1'b0);

      // Same word with a 3-cycle in_valid gap after bit 3
      t0 = cyc;
      send_range(8'hA5, 0, 3);
      idle(3);
      send_range(8'hA5, 4, NB - 1);
      check("t2_out", out, 8'hA5);
      check("t2_valid", out_valid, 1'b1);
      check("t2_latency", cyc - t0, NB + 3);
      idle(1);

      // Back-pressure: second word overruns
      out_ready = 1'b0;
      send_range(8'h3C, 0, NB - 1);
      check("t3_out_first", out, 8'h3C);
      check("t3_valid_first", out_valid, 1'b1);
      send_range(8'hC3, 0, NB - 2);
      check("t3_no_early_overrun", overrun, 1'b0);
      check("t3_out_held", out, 8'h3C);
      send_range(8'hC3, NB - 1, NB - 1);
      check("t3_overrun", overrun, 1'b1);
      check("t3_out_kept", out, 8'h3C);
      check("t3_valid_kept", out_valid, 1'b1);
      idle(1);
      check("t3_overrun_pulse", overrun, 1'b0);
      out_ready = 1'b1;
      idle(1);
      check("t3_valid_cleared", out_valid, 1'b0);
      check("t3_out_after_accept", out, 8'h3C);

      // Early frame restarts the word
      send_range(8'hB0, 0, 3);
      check("t4_no_frame_err", frame_err, 1'b0);
      send_range(8'hFF, 0, 0);
      check("t4_frame_err", frame_err, 1'b1);
      send_range(8'hFF, 1, 1);
      check("t4_frame_err_pulse", frame_err, 1'b0);
      send_range(8'hFF, 2, NB - 1);
      check("t4_out", out, 8'hFF);
      check("t4_valid", out_valid, 1'b1);
      idle(1);

      // Reset mid-word discards the partial word
      send_range(8'h5A, 0, 4);
      reset = 1'b0;
      #1;
      check("t5_async_out", out, 8'h00);
      check("t5_async_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      send_range(8'h5A, 5, NB - 1);
      check("t5_no_aborted_word", out_valid, 1'b0);
      send_range(8'h0F, 0, NB - 1);
      check("t5_out", out, 8'h0F);
      check("t5_valid", out_valid, 1'b1);
      idle(1);

      // Completion coinciding with acceptance
      out_ready = 1'b0;
      send_range(8'hA5, 0, NB - 1);
      check("t6_out_first", out, 8'hA5);
      send_range(8'h3C, 0, NB - 2);
      out_ready = 1'b1;
      send_range(8'h3C, NB - 1, NB - 1);
      check("t6_out", out, 8'h3C);
      check("t6_valid", out_valid, 1'b1);
      check("t6_overrun", overrun, 1'b0);
      idle(1);
      check("t6_valid_cleared", out_valid, 1'b0);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
      send_range(8'h07, 0, W - 1);
      drive_bit(1'b1, 1'b0);
      check("p_good_out", out, 8'h07);
      check("p_good_perr", parity_err, 1'b0);
      idle(1);
      send_range(8'h07, 0, W - 1);
      drive_bit(1'b0, 1'b0);
      check("p_bad_out", out, 8'h07);
      check("p_bad_valid", out_valid, 1'b1);
      check("p_bad_perr", parity_err, 1'b1);
      idle(1);
      send_range(8'h07, 0, W - 1);
      drive_bit(1'b1, 1'b1);
      check("p_frame_on_parity", frame_err, 1'b1);
      check("p_frame_no_word", out_valid, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
